// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_pkg
//  Description : Shared constants and state encoding for the frame packer.
//                SYNC0/SYNC1 are the two frame-header bytes, COUNT_W is the
//                width of the per-frame sample counter, state_e is the
//                packer state machine encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_pkg;

    localparam logic [7:0] SYNC0   = 8'hA5;
    localparam logic [7:0] SYNC1   = 8'h5A;
    localparam int         COUNT_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR0    = 3'd1,
        HDR1    = 3'd2,
        SAMP_HI = 3'd3,
        SAMP_LO = 3'd4,
        CNT_HI  = 3'd5,
        CNT_LO  = 3'd6,
        CSUM    = 3'd7
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sample_fifo
//  Description : Single-clock synchronous FIFO, depth 2**AW, show-ahead read
//                (rd_data_o is the head entry whenever empty_o is low).
//                A push while full is accepted only if a pop happens in the
//                same cycle; otherwise it is ignored.
//  Ports       : rd_clk, rst_n (sync, active-low)
//                push_i/wr_data_i  - write request and data
//                pop_i             - remove head entry (ignored when empty)
//                rd_data_o         - head entry
//                full_o / empty_o  - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int WIDTH = 13,
    parameter int AW    = 4
) (
    input  logic             rd_clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge rd_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_packer
//  Description : Buffers DATA_WIDTH-bit samples and serialises each frame as
//                A5 5A {hi lo}* COUNT[15:8] COUNT[7:0] CSUM on an 8-bit
//                valid/ready stream. CSUM is the XOR of sample and count
//                bytes. m_last marks the CSUM byte.
//  Ports       : rd_clk, rst_n (sync, active-low)
//                s_data/s_valid/s_last - sample input, no backpressure
//                m_data/m_valid/m_ready/m_last - byte stream output
//                overflow - sticky, a sample was dropped on a full buffer
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_packer
    import frame_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int FIFO_AW    = 4
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  overflow
);

    state_e               state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [7:0]           csum_q, csum_d;
    logic                 overflow_q;

    logic [DATA_WIDTH:0]  fifo_rd;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;

    logic                 head_last;
    logic [7:0]           head_hi;
    logic [7:0]           head_lo;

    // Samples arriving during reset are ignored.
    assign fifo_push = rst_n && s_valid;

    sample_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .AW    (FIFO_AW)
    ) u_fifo (
        .rd_clk    (rd_clk),
        .rst_n     (rst_n),
        .push_i    (fifo_push),
        .wr_data_i ({s_last, s_data}),
        .pop_i     (fifo_pop),
        .rd_data_o (fifo_rd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign head_last = fifo_rd[DATA_WIDTH];
    assign head_hi   = 8'(fifo_rd[DATA_WIDTH-1:8]);
    assign head_lo   = fifo_rd[7:0];

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            csum_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            csum_q  <= csum_d;
            if (s_valid && fifo_full && !fifo_pop) overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;

    // Outputs are decoded from the state and the FIFO head only; neither
    // changes while a byte is stalled, so m_data/m_last hold by construction.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        csum_d   = csum_q;
        m_valid  = 1'b0;
        m_data   = 8'h00;
        m_last   = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = HDR0;
            end
            HDR0: begin
                m_valid = 1'b1;
                m_data  = SYNC0;
                count_d = '0;
                csum_d  = '0;
                if (m_ready) state_d = HDR1;
            end
            HDR1: begin
                m_valid = 1'b1;
                m_data  = SYNC1;
                if (m_ready) state_d = SAMP_HI;
            end
            SAMP_HI: begin
                // Empty here means the source is mid-frame: wait for it.
                m_valid = !fifo_empty;
                m_data  = head_hi;
                if (!fifo_empty && m_ready) begin
                    csum_d  = csum_q ^ head_hi;
                    state_d = SAMP_LO;
                end
            end
            SAMP_LO: begin
                m_valid = 1'b1;
                m_data  = head_lo;
                if (m_ready) begin
                    fifo_pop = 1'b1;
                    count_d  = count_q + COUNT_W'(1);
                    csum_d   = csum_q ^ head_lo;
                    state_d  = head_last ? CNT_HI : SAMP_HI;
                end
            end
            CNT_HI: begin
                m_valid = 1'b1;
                m_data  = count_q[15:8];
                if (m_ready) begin
                    csum_d  = csum_q ^ count_q[15:8];
                    state_d = CNT_LO;
                end
            end
            CNT_LO: begin
                m_valid = 1'b1;
                m_data  = count_q[7:0];
                if (m_ready) begin
                    csum_d  = csum_q ^ count_q[7:0];
                    state_d = CSUM;
                end
            end
            CSUM: begin
                m_valid = 1'b1;
                m_data  = csum_q;
                m_last  = 1'b1;
                if (m_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_packer
//  Description : Self-checking bench for frame_packer. Expected bytes are
//                queued when samples are driven and compared as the DUT
//                hands them over; stalled bytes must hold steady.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_packer;

    localparam int DW = 12;
    localparam int AW = 4;

    logic          rd_clk  = 1'b0;
    logic          rst_n   = 1'b0;
    logic [DW-1:0] s_data  = '0;
    logic          s_valid = 1'b0;
    logic          s_last  = 1'b0;
    logic          m_ready = 1'b0;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_last;
    logic          overflow;

    frame_packer #(
        .DATA_WIDTH (DW),
        .FIFO_AW    (AW)
    ) dut (
        .rd_clk   (rd_clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .overflow (overflow)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       hdr;
    } exp_t;

    typedef struct {
        int                   n;
        logic [0:3][DW-1:0]   smp;
        int                   rmode;
        int                   nexp;
        logic [0:15][7:0]     bytes;
    } vec_t;

    exp_t          exp_q[$];
    vec_t          vecs[4];
    int            n_tests  = 0;
    int            n_fail   = 0;
    int            rmode    = 3;   // 0 always ready, 1 toggle, 2 random, 3 never
    int            cyc      = 0;
    int            csum_cyc = -100;
    int            hdr_gap  = 0;
    logic [DW-1:0] smp[32];
    logic          lst[32];

    task automatic check(input string name, input int got, input int need);
        n_tests++;
        if (got != need) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", name, got, need);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic l, input logic h);
        exp_t e;
        e.data = d;
        e.last = l;
        e.hdr  = h;
        exp_q.push_back(e);
    endtask

    // Reference frame builder from smp[0..n-1].
    task automatic push_model(input int n);
        logic [7:0]  cs;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] cnt;
        cs  = 8'h00;
        cnt = 16'(n);
        push_exp(8'hA5, 1'b0, 1'b1);
        push_exp(8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            hi = {4'h0, smp[i][11:8]};
            lo = smp[i][7:0];
            cs = cs ^ hi ^ lo;
            push_exp(hi, 1'b0, 1'b0);
            push_exp(lo, 1'b0, 1'b0);
        end
        cs = cs ^ cnt[15:8] ^ cnt[7:0];
        push_exp(cnt[15:8], 1'b0, 1'b0);
        push_exp(cnt[7:0], 1'b0, 1'b0);
        push_exp(cs, 1'b1, 1'b0);
    endtask

    // Called just after a rising edge; drives smp/lst back-to-back.
    task automatic drive(input int n);
        for (int i = 0; i < n; i++) begin
            s_data  = smp[i];
            s_last  = lst[i];
            s_valid = 1'b1;
            @(posedge rd_clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            @(posedge rd_clk);
            k++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d bytes pending, need 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge rd_clk);
        #1;
        check({name, "_idle_after"}, int'(m_valid), 0);
    endtask

    initial begin
        // Vector table: inputs, ready pattern and the exact byte stream.
        vecs[0].n = 3; vecs[0].rmode = 0; vecs[0].nexp = 11;
        vecs[0].smp   = {12'h123, 12'h456, 12'hABC, 12'h000};
        vecs[0].bytes = {8'hA5, 8'h5A, 8'h01, 8'h23, 8'h04, 8'h56, 8'h0A, 8'hBC,
                         8'h00, 8'h03, 8'hC5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1] = vecs[0];
        vecs[1].rmode = 1;
        vecs[2].n = 2; vecs[2].rmode = 0; vecs[2].nexp = 9;
        vecs[2].smp   = {12'h000, 12'hFFF, 12'h000, 12'h000};
        vecs[2].bytes = {8'hA5, 8'h5A, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'h00, 8'h02,
                         8'hF2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].n = 4; vecs[3].rmode = 2; vecs[3].nexp = 13;
        vecs[3].smp   = {12'h9A5, 12'h0FF, 12'h300, 12'hE01};
        vecs[3].bytes = {8'hA5, 8'h5A, 8'h09, 8'hA5, 8'h00, 8'hFF, 8'h03, 8'h00,
                         8'h0E, 8'h01, 8'h00, 8'h04, 8'h5B, 8'h00, 8'h00, 8'h00};

        fork
            // Ready pattern generator.
            forever begin
                @(posedge rd_clk);
                #1;
                case (rmode)
                    0:       m_ready = 1'b1;
                    1:       m_ready = ~m_ready;
                    2:       m_ready = 1'($urandom_range(0, 1));
                    default: m_ready = 1'b0;
                endcase
            end
            // Output monitor: scoreboard pop and stall stability.
            begin : mon
                logic       prev_stall;
                logic [7:0] prev_data;
                logic       prev_last;
                exp_t       e;
                prev_stall = 1'b0;
                prev_data  = 8'h00;
                prev_last  = 1'b0;
                forever begin
                    @(negedge rd_clk);
                    cyc++;
                    if (!rst_n) begin
                        prev_stall = 1'b0;
                    end else begin
                        if (prev_stall) begin
                            n_tests++;
                            if (!(m_valid === 1'b1 && m_data === prev_data && m_last === prev_last)) begin
                                n_fail++;
                                $display("FAIL stall_hold: got v=%0b d=%02h l=%0b, need v=1 d=%02h l=%0b",
                                         m_valid, m_data, m_last, prev_data, prev_last);
                            end
                        end
                        if (m_valid && m_ready) begin
                            n_tests++;
                            if (exp_q.size() == 0) begin
                                n_fail++;
                                $display("FAIL unexpected_byte: got %02h, need no byte", m_data);
                            end else begin
                                e = exp_q.pop_front();
                                if (m_data !== e.data || m_last !== e.last) begin
                                    n_fail++;
                                    $display("FAIL byte: got %02h last=%0b, need %02h last=%0b",
                                             m_data, m_last, e.data, e.last);
                                end
                                if (e.hdr)  hdr_gap  = cyc - csum_cyc;
                                if (e.last) csum_cyc = cyc;
                            end
                        end
                        prev_stall = m_valid && !m_ready;
                        prev_data  = m_data;
                        prev_last  = m_last;
                    end
                end
            end
        join_none

        // Reset state.
        repeat (3) @(posedge rd_clk);
        #1;
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_m_last", int'(m_last), 0);
        check("rst_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        @(posedge rd_clk);
        #1;

        // Table-driven frames.
        for (int v = 0; v < 4; v++) begin
            rmode = vecs[v].rmode;
            for (int j = 0; j < vecs[v].nexp; j++)
                push_exp(vecs[v].bytes[j], 1'(j == vecs[v].nexp - 1), 1'(j == 0));
            for (int j = 0; j < vecs[v].n; j++) begin
                smp[j] = vecs[v].smp[j];
                lst[j] = (j == vecs[v].n - 1);
            end
            drive(vecs[v].n);
            drain($sformatf("vec%0d", v));
        end

        // Overflow: 20 samples into a 16-deep buffer with the sink stalled.
        rmode = 3;
        repeat (2) @(posedge rd_clk);
        #1;
        check("ovf_before", int'(overflow), 0);
        for (int i = 0; i < 20; i++) begin
            smp[i] = 12'h100 + 12'(i * 7);
            lst[i] = (i == 15) || (i == 19);
        end
        push_model(16);
        drive(20);
        check("ovf_set", int'(overflow), 1);
        repeat (5) @(posedge rd_clk);
        #1;
        rmode = 0;
        drain("ovf_frame");
        check("ovf_sticky", int'(overflow), 1);

        // Reset mid-frame after byte 0x01.
        smp[0] = 12'h123; lst[0] = 1'b0;
        smp[1] = 12'h456; lst[1] = 1'b0;
        smp[2] = 12'hABC; lst[2] = 1'b1;
        push_exp(8'hA5, 1'b0, 1'b1);
        push_exp(8'h5A, 1'b0, 1'b0);
        push_exp(8'h01, 1'b0, 1'b0);
        drive(3);
        begin
            int k;
            k = 0;
            while (exp_q.size() != 0 && k < 200) begin
                @(posedge rd_clk);
                k++;
            end
            if (exp_q.size() != 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL midrst_timeout: got %0d bytes pending, need 0", exp_q.size());
                exp_q.delete();
            end
        end
        #1;
        rst_n = 1'b0;
        @(posedge rd_clk);
        #1;
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_m_data", int'(m_data), 0);
        check("midrst_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        @(posedge rd_clk);
        #1;
        check("midrst_idle", int'(m_valid), 0);
        smp[0] = 12'h7FF; lst[0] = 1'b1;
        push_exp(8'hA5, 1'b0, 1'b1);
        push_exp(8'h5A, 1'b0, 1'b0);
        push_exp(8'h07, 1'b0, 1'b0);
        push_exp(8'hFF, 1'b0, 1'b0);
        push_exp(8'h00, 1'b0, 1'b0);
        push_exp(8'h01, 1'b0, 1'b0);
        push_exp(8'hF9, 1'b1, 1'b0);
        drive(1);
        drain("midrst_frame");

        // Two single-sample frames back-to-back.
        smp[0] = 12'h001; lst[0] = 1'b1;
        smp[1] = 12'h002; lst[1] = 1'b1;
        push_model(1);
        push_exp(8'hA5, 1'b0, 1'b1);
        push_exp(8'h5A, 1'b0, 1'b0);
        push_exp(8'h00, 1'b0, 1'b0);
        push_exp(8'h02, 1'b0, 1'b0);
        push_exp(8'h00, 1'b0, 1'b0);
        push_exp(8'h01, 1'b0, 1'b0);
        push_exp(8'h03, 1'b1, 1'b0);
        drive(2);
        drain("b2b");
        check("b2b_gap", hdr_gap, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_packer.md
FRAME_PACKER -- requirements
Module: frame_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, sample width; legal range 9..16.
REQ-002 SHALL have parameter FIFO_AW, default 4, sample-buffer address width, giving depth 2^FIFO_AW.
REQ-003 SHALL have port rd_clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port s_data, input, DATA_WIDTH, sample from the upstream capture RAM read side.
REQ-006 SHALL have port s_valid, input, 1, s_data valid this cycle; no backpressure toward the source.
REQ-007 SHALL have port s_last, input, 1, marks the final sample of a frame; sampled only with s_valid.
REQ-008 SHALL have port m_data, output, 8, byte stream out.
REQ-009 SHALL have port m_valid, output, 1, m_data valid.
REQ-010 SHALL have port m_ready, input, 1, downstream accepts the byte when m_valid and m_ready are both high.
REQ-011 SHALL have port m_last, output, 1, high on the checksum byte only.
REQ-012 SHALL have port overflow, output, 1, sticky flag: a sample was dropped.

Function
REQ-013 SHALL write {s_last, s_data} into the sample FIFO on every cycle with s_valid high, unless the FIFO is full and not popped that cycle.
REQ-014 SHALL accept a write when the FIFO is full and a pop occurs in the same cycle, leaving occupancy unchanged.
REQ-015 SHALL drop the sample on a write to a full FIFO with no pop, set overflow, and exclude the sample from the count; if it carried s_last, the frame SHALL still terminate at the next dequeued sample marked last.
REQ-016 SHALL emit each frame as bytes 0xA5, 0x5A, then per sample {zero-extended s_data[DW-1:8]} and s_data[7:0], then COUNT[15:8], COUNT[7:0], then CSUM.
REQ-017 SHALL use a state machine with states IDLE, HDR0, HDR1, SAMP_HI, SAMP_LO, CNT_HI, CNT_LO, CSUM.
REQ-018 SHALL advance states only on an accepted byte (m_valid & m_ready), except IDLE->HDR0, which occurs on the first cycle the FIFO is non-empty.
REQ-019 SHALL drive m_valid high in HDR0 the cycle after IDLE sees a non-empty FIFO; minimum latency is 2 cycles from s_valid to the first m_valid.
REQ-020 SHALL move SAMP_LO->SAMP_HI when the popped entry is not marked last, and SAMP_LO->CNT_HI when it is marked last.
REQ-021 SHALL pop a FIFO entry on acceptance of SAMP_LO.
REQ-022 SHALL, in SAMP_HI, hold m_valid low while the FIFO is empty; the source is then mid-frame.
REQ-023 SHALL keep COUNT as a 16-bit count of dequeued samples, modulo 2^16, cleared at HDR0.
REQ-024 SHALL compute CSUM as the 8-bit XOR of all bytes from the first sample byte through COUNT[7:0], cleared at HDR0.
REQ-025 SHALL move CSUM -> IDLE on acceptance.
REQ-026 SHALL start the next frame from IDLE with no gap beyond REQ-019 when samples are already queued.
REQ-027 SHALL hold m_data, m_last and state stable while m_valid is high and m_ready is low.
REQ-028 SHALL clear overflow only by reset.

Reset
REQ-029 SHALL, while rst_n is low, set state to IDLE, m_valid 0, m_last 0, m_data 0x00, overflow 0, COUNT 0, CSUM 0, and empty the FIFO pointers; s_valid SHALL be ignored.
REQ-030 SHALL, on reset mid-frame, abandon the partial frame with no trailer; the next frame SHALL start with 0xA5.

Structure
REQ-031 SHALL take SYNC0=8'hA5, SYNC1=8'h5A, the state encoding and COUNT width=16 from shared package frame_pkg.
REQ-032 SHALL implement the buffer as sub-module sample_fifo (synchronous, single clock, width DATA_WIDTH+1, full/empty outputs).

Verification
REQ-033 SHALL verify: samples 0x123, 0x456, 0xABC (last on 3rd) with m_ready=1 -> A5 5A 01 23 04 56 0A BC 00 03 C5, m_last on C5.
REQ-034 SHALL verify: the same frame with m_ready toggling 1/0 every cycle -> identical byte sequence, with outputs stable during stalls.
REQ-035 SHALL verify: 20 back-to-back samples, FIFO_AW=4, m_ready=0 -> 16 accepted, overflow=1, and after m_ready=1 the frame carries COUNT 0x0010.
REQ-036 SHALL verify: rst_n pulsed low after the byte 0x01 of REQ-033 -> m_valid 0 next cycle; new frame 0x7FF (last) -> A5 5A 07 FF 00 01 F9.
REQ-037 SHALL verify: two single-sample frames 0x001 and 0x002 queued back-to-back -> two complete frames, the second starting immediately after the first's CSUM is accepted.
